sargantana_icache_fill_arbiter: RTL and testbench

//  Owns the single iFill port between the instruction cache and the upper memory levels.
//  Two requesters share it: demand misses and the next-line prefetcher. Demand has priority,
//  and an anti-starvation counter guarantees prefetch progress.
//  The block tracks the one outstanding fill, handles kill/flush by draining it,
//  and promotes an in-flight prefetch when a demand miss hits the same line.

---
 rtl/sargantana_icache_pkg.sv | 23 ++
 rtl/sargantana_icache_fill_arbiter_if.sv | 55 +++++
 rtl/sargantana_icache_fill_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sargantana_icache_fill_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sargantana_icache_pkg.sv
// rtl/sargantana_icache_pkg.sv - shared types and defaults for the icache fill path
//
// Purpose: state and source encodings for the iFill arbiter, plus the default
//          prefetch anti-starvation threshold.
// Ports:   none (package)

package sargantana_icache_pkg;

   typedef enum logic [1:0] {
      FILL_IDLE,
      FILL_REQ,
      FILL_WAIT,
      FILL_DRAIN
   } fill_state_t;

   typedef enum logic {
      FILL_SRC_DMD,
      FILL_SRC_PF
   } fill_src_t;

   localparam logic [3:0] PF_STARVE_DEF = 4'd15;

endpackage

// File: rtl/sargantana_icache_fill_arbiter_if.sv
// rtl/sargantana_icache_fill_arbiter_if.sv - request, iFill and response bundle of the fill arbiter
//
// Purpose: groups the demand/prefetch request channels, the upper-level iFill
//          port, the cache response and status signals. Suffixes _i/_o are seen
//          from the arbiter side.
// Modports:
//   slave  - the arbiter (consumes requests and iFill responses)
//   master - the environment (requesters, upper memory level, cache)

interface sargantana_icache_fill_arbiter_if #(
   parameter int PADDR_SIZE       = 40,
   parameter int ICACHE_MEM_BLOCK = 256
);

   logic                        flush_i;
   logic                        dmd_req_valid_i;
   logic [PADDR_SIZE-1:0]       dmd_req_paddr_i;
   logic                        dmd_req_ready_o;
   logic                        dmd_kill_i;
   logic                        pf_req_valid_i;
   logic [PADDR_SIZE-1:0]       pf_req_paddr_i;
   logic                        pf_req_ready_o;
   logic                        ifill_req_valid_o;
   logic [PADDR_SIZE-1:0]       ifill_req_paddr_o;
   logic                        ifill_resp_ack_i;
   logic                        ifill_resp_valid_i;
   logic [ICACHE_MEM_BLOCK-1:0] ifill_resp_data_i;
   logic                        resp_valid_o;
   logic                        resp_src_o;
   logic [PADDR_SIZE-1:0]       resp_paddr_o;
   logic [ICACHE_MEM_BLOCK-1:0] resp_data_o;
   logic                        busy_o;
   logic                        fill_wait_pmu_o;

   modport slave (
      input  flush_i, dmd_req_valid_i, dmd_req_paddr_i, dmd_kill_i,
      input  pf_req_valid_i, pf_req_paddr_i,
      input  ifill_resp_ack_i, ifill_resp_valid_i, ifill_resp_data_i,
      output dmd_req_ready_o, pf_req_ready_o,
      output ifill_req_valid_o, ifill_req_paddr_o,
      output resp_valid_o, resp_src_o, resp_paddr_o, resp_data_o,
      output busy_o, fill_wait_pmu_o
   );

   modport master (
      output flush_i, dmd_req_valid_i, dmd_req_paddr_i, dmd_kill_i,
      output pf_req_valid_i, pf_req_paddr_i,
      output ifill_resp_ack_i, ifill_resp_valid_i, ifill_resp_data_i,
      input  dmd_req_ready_o, pf_req_ready_o,
      input  ifill_req_valid_o, ifill_req_paddr_o,
      input  resp_valid_o, resp_src_o, resp_paddr_o, resp_data_o,
      input  busy_o, fill_wait_pmu_o
   );

endinterface

// File: rtl/sargantana_icache_fill_arbiter.sv
// rtl/sargantana_icache_fill_arbiter.sv - single-outstanding iFill arbiter between demand and prefetch
//
// Purpose: grants the iFill port to demand misses (priority) or the next-line
//          prefetcher (guaranteed a grant after PF_STARVE lost arbitrations),
//          tracks the one outstanding fill, drains killed fills and promotes an
//          in-flight prefetch to demand on a same-line miss.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   bus    - request/iFill/response bundle (slave modport)

module sargantana_icache_fill_arbiter
   import sargantana_icache_pkg::*;
#(
   parameter int         PADDR_SIZE       = 40,
   parameter int         ICACHE_MEM_BLOCK = 256,
   parameter int         LINE_OFF_BITS    = 5,
   parameter logic [3:0] PF_STARVE        = PF_STARVE_DEF
) (
   input logic                             clk_i,
   input logic                             rst_i,
   sargantana_icache_fill_arbiter_if.slave bus
);

   localparam logic [PADDR_SIZE-1:0] LINE_MASK =
      {{(PADDR_SIZE-LINE_OFF_BITS){1'b1}}, {LINE_OFF_BITS{1'b0}}};

   fill_state_t                 r_state;
   fill_state_t                 w_state_nxt;
   fill_src_t                   r_src;
   logic [PADDR_SIZE-1:0]       r_paddr;
   logic [3:0]                  r_starve_cnt;
   logic                        r_resp_valid;
   fill_src_t                   r_resp_src;
   logic [PADDR_SIZE-1:0]       r_resp_paddr;
   logic [ICACHE_MEM_BLOCK-1:0] r_resp_data;

   logic w_fill_live;
   logic w_kill;
   logic w_line_hit;
   logic w_promote;
   logic w_can_grant;
   logic w_pf_starved;
   logic w_grant_dmd;
   logic w_grant_pf;
   logic w_resp_beat;
   logic w_deliver;

   assign w_fill_live  = (r_state == FILL_REQ) || (r_state == FILL_WAIT);
   // dmd_kill_i only cancels demand fills; prefetches die on flush alone
   assign w_kill       = w_fill_live &&
                         (bus.flush_i || (bus.dmd_kill_i && (r_src == FILL_SRC_DMD)));
   assign w_line_hit   = bus.dmd_req_paddr_i[PADDR_SIZE-1:LINE_OFF_BITS] ==
                         r_paddr[PADDR_SIZE-1:LINE_OFF_BITS];
   assign w_promote    = !rst_i && w_fill_live && (r_src == FILL_SRC_PF) &&
                         bus.dmd_req_valid_i && w_line_hit &&
                         !bus.flush_i && !bus.dmd_kill_i;
   // the cycle a response is presented to the cache is never a grant cycle
   assign w_can_grant  = !rst_i && (r_state == FILL_IDLE) && !bus.flush_i &&
                         !bus.dmd_kill_i && !r_resp_valid;
   assign w_pf_starved = bus.pf_req_valid_i && (r_starve_cnt == PF_STARVE);
   assign w_grant_dmd  = w_can_grant && bus.dmd_req_valid_i && !w_pf_starved;
   assign w_grant_pf   = w_can_grant && bus.pf_req_valid_i && !w_grant_dmd;
   // a response beat belongs to the live fill once the request was acked
   assign w_resp_beat  = bus.ifill_resp_valid_i &&
                         (((r_state == FILL_REQ) && bus.ifill_resp_ack_i) ||
                          (r_state == FILL_WAIT));
   assign w_deliver    = w_resp_beat && !w_kill;

   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= FILL_IDLE;
      else       r_state <= w_state_nxt;
   end

   // next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FILL_IDLE: begin
            if (w_grant_dmd || w_grant_pf) w_state_nxt = FILL_REQ;
         end
         FILL_REQ: begin
            if (bus.ifill_resp_ack_i) begin
               if (bus.ifill_resp_valid_i) w_state_nxt = FILL_IDLE;
               else if (w_kill)            w_state_nxt = FILL_DRAIN;
               else                        w_state_nxt = FILL_WAIT;
            end else if (w_kill) begin
               w_state_nxt = FILL_IDLE;
            end
         end
         FILL_WAIT: begin
            if (bus.ifill_resp_valid_i) w_state_nxt = FILL_IDLE;
            else if (w_kill)            w_state_nxt = FILL_DRAIN;
         end
         FILL_DRAIN: begin
            if (bus.ifill_resp_valid_i) w_state_nxt = FILL_IDLE;
         end
         default: w_state_nxt = FILL_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      bus.ifill_req_valid_o = 1'b0;
      bus.busy_o            = 1'b0;
      bus.fill_wait_pmu_o   = 1'b0;
      bus.dmd_req_ready_o   = 1'b0;
      bus.pf_req_ready_o    = 1'b0;
      if (!rst_i) begin
         bus.ifill_req_valid_o = (r_state == FILL_REQ);
         bus.busy_o            = (r_state != FILL_IDLE);
         bus.fill_wait_pmu_o   = w_fill_live && (r_src == FILL_SRC_DMD);
         bus.dmd_req_ready_o   = w_grant_dmd || w_promote;
         bus.pf_req_ready_o    = w_grant_pf;
      end
   end

   // fill tracking, starvation counter and registered response
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_src        <= FILL_SRC_DMD;
         r_paddr      <= '0;
         r_starve_cnt <= '0;
         r_resp_valid <= 1'b0;
         r_resp_src   <= FILL_SRC_DMD;
         r_resp_paddr <= '0;
         r_resp_data  <= '0;
      end else begin
         if (w_grant_dmd) begin
            r_paddr <= bus.dmd_req_paddr_i & LINE_MASK;
            r_src   <= FILL_SRC_DMD;
         end else if (w_grant_pf) begin
            r_paddr <= bus.pf_req_paddr_i & LINE_MASK;
            r_src   <= FILL_SRC_PF;
         end else if (w_promote) begin
            r_src   <= FILL_SRC_DMD;
         end

         // counts arbitrations a pending prefetch lost to demand
         if (w_grant_pf)
            r_starve_cnt <= '0;
         else if (w_grant_dmd && bus.pf_req_valid_i && (r_starve_cnt != 4'hF))
            r_starve_cnt <= r_starve_cnt + 4'd1;

         r_resp_valid <= w_deliver;
         if (w_deliver) begin
            r_resp_src   <= w_promote ? FILL_SRC_DMD : r_src;
            r_resp_paddr <= r_paddr;
            r_resp_data  <= bus.ifill_resp_data_i;
         end
      end
   end

   assign bus.ifill_req_paddr_o = r_paddr;
   assign bus.resp_valid_o      = r_resp_valid;
   assign bus.resp_src_o        = (r_resp_src == FILL_SRC_PF);
   assign bus.resp_paddr_o      = r_resp_paddr;
   assign bus.resp_data_o       = r_resp_data;

endmodule

// File: tb/tb_sargantana_icache_fill_arbiter.sv
// tb/tb_sargantana_icache_fill_arbiter.sv - directed self-checking bench for the iFill arbiter

module tb_sargantana_icache_fill_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   sargantana_icache_fill_arbiter_if bus ();

   sargantana_icache_fill_arbiter dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle_inputs();
      bus.flush_i            = 1'b0;
      bus.dmd_req_valid_i    = 1'b0;
      bus.dmd_req_paddr_i    = '0;
      bus.dmd_kill_i         = 1'b0;
      bus.pf_req_valid_i     = 1'b0;
      bus.pf_req_paddr_i     = '0;
      bus.ifill_resp_ack_i   = 1'b0;
      bus.ifill_resp_valid_i = 1'b0;
      bus.ifill_resp_data_i  = '0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_busy"},      bus.busy_o,            1'b0);
      check({tag, "_req_valid"}, bus.ifill_req_valid_o, 1'b0);
      check({tag, "_resp_valid"},bus.resp_valid_o,      1'b0);
      check({tag, "_dmd_ready"}, bus.dmd_req_ready_o,   1'b0);
      check({tag, "_pf_ready"},  bus.pf_req_ready_o,    1'b0);
      check({tag, "_pmu"},       bus.fill_wait_pmu_o,   1'b0);
   endtask

   initial begin
      logic [255:0] d1, d2, d3;
      logic [39:0]  exp_addr;
      d1 = {8{32'hA5A5_0001}};
      d2 = {8{32'h5A5A_0002}};
      d3 = {8{32'hC3C3_0003}};

      // reset
      idle_inputs();
      rst = 1'b1;
      cyc();
      cyc();
      settle();
      check_quiet("rst");
      check("rst_req_paddr",  bus.ifill_req_paddr_o, 40'h0);
      check("rst_resp_paddr", bus.resp_paddr_o,      40'h0);
      check("rst_resp_data",  bus.resp_data_o,       256'h0);
      rst = 1'b0;
      cyc();

      // 1: demand fill, ack two cycles in, response later
      bus.dmd_req_valid_i = 1'b1;
      bus.dmd_req_paddr_i = 40'h80_0000_1234;
      settle();
      check("t1_dmd_ready", bus.dmd_req_ready_o, 1'b1);
      check("t1_pf_ready",  bus.pf_req_ready_o,  1'b0);
      cyc();
      bus.dmd_req_valid_i = 1'b0;
      settle();
      check("t1_req_valid", bus.ifill_req_valid_o, 1'b1);
      check("t1_req_paddr", bus.ifill_req_paddr_o, 40'h80_0000_1220);
      check("t1_pmu_req",   bus.fill_wait_pmu_o,   1'b1);
      cyc();
      settle();
      check("t1_req_hold",  bus.ifill_req_valid_o, 1'b1);
      check("t1_paddr_hold",bus.ifill_req_paddr_o, 40'h80_0000_1220);
      bus.ifill_resp_ack_i = 1'b1;
      cyc();
      bus.ifill_resp_ack_i = 1'b0;
      settle();
      check("t1_wait_req_valid", bus.ifill_req_valid_o, 1'b0);
      check("t1_wait_busy",      bus.busy_o,            1'b1);
      check("t1_wait_pmu",       bus.fill_wait_pmu_o,   1'b1);
      cyc();
      cyc();
      bus.ifill_resp_valid_i = 1'b1;
      bus.ifill_resp_data_i  = d1;
      settle();
      check("t1_resp_not_early", bus.resp_valid_o, 1'b0);
      cyc();
      bus.ifill_resp_valid_i = 1'b0;
      bus.dmd_req_valid_i    = 1'b1;
      bus.dmd_req_paddr_i    = 40'h6000;
      settle();
      check("t1_resp_valid", bus.resp_valid_o, 1'b1);
      check("t1_resp_src",   bus.resp_src_o,   1'b0);
      check("t1_resp_paddr", bus.resp_paddr_o, 40'h80_0000_1220);
      check("t1_resp_data",  bus.resp_data_o,  d1);
      check("t1_idle_busy",  bus.busy_o,       1'b0);
      check("t1_no_grant_on_resp", bus.dmd_req_ready_o, 1'b0);
      cyc();
      settle();
      check("t1_resp_one_cycle", bus.resp_valid_o,    1'b0);
      check("t1_grant_resumes",  bus.dmd_req_ready_o, 1'b1);

      // 5a: ack and response in the same cycle
      cyc();
      bus.dmd_req_valid_i    = 1'b0;
      bus.ifill_resp_ack_i   = 1'b1;
      bus.ifill_resp_valid_i = 1'b1;
      bus.ifill_resp_data_i  = d2;
      settle();
      check("t5_req_valid", bus.ifill_req_valid_o, 1'b1);
      cyc();
      bus.ifill_resp_ack_i   = 1'b0;
      bus.ifill_resp_valid_i = 1'b0;
      settle();
      check("t5_busy",       bus.busy_o,       1'b0);
      check("t5_resp_valid", bus.resp_valid_o, 1'b1);
      check("t5_resp_paddr", bus.resp_paddr_o, 40'h6000);
      check("t5_resp_data",  bus.resp_data_o,  d2);
      cyc();

      // 2: contention; prefetch wins after 15 lost arbitrations, then demand again
      for (int i = 0; i < 17; i++) begin
         bus.dmd_req_valid_i = 1'b1;
         bus.dmd_req_paddr_i = 40'h1000 + 40'(i * 64);
         bus.pf_req_valid_i  = 1'b1;
         bus.pf_req_paddr_i  = 40'h9008;
         settle();
         check($sformatf("t2_dmd_ready_%0d", i), bus.dmd_req_ready_o, (i != 15));
         check($sformatf("t2_pf_ready_%0d", i),  bus.pf_req_ready_o,  (i == 15));
         exp_addr = (i == 15) ? 40'h9000 : 40'h1000 + 40'(i * 64);
         cyc();
         bus.dmd_req_valid_i  = 1'b0;
         bus.pf_req_valid_i   = 1'b0;
         bus.ifill_resp_ack_i = 1'b1;
         cyc();
         bus.ifill_resp_ack_i   = 1'b0;
         bus.ifill_resp_valid_i = 1'b1;
         bus.ifill_resp_data_i  = 256'(i);
         cyc();
         bus.ifill_resp_valid_i = 1'b0;
         settle();
         check($sformatf("t2_src_%0d", i),   bus.resp_src_o,   (i == 15));
         check($sformatf("t2_paddr_%0d", i), bus.resp_paddr_o, exp_addr);
         cyc();
      end

      // 3: prefetch in WAIT promoted by a same-line demand
      bus.pf_req_valid_i = 1'b1;
      bus.pf_req_paddr_i = 40'h100;
      settle();
      check("t3_pf_ready", bus.pf_req_ready_o, 1'b1);
      cyc();
      bus.pf_req_valid_i   = 1'b0;
      bus.ifill_resp_ack_i = 1'b1;
      cyc();
      bus.ifill_resp_ack_i = 1'b0;
      bus.dmd_req_valid_i  = 1'b1;
      bus.dmd_req_paddr_i  = 40'h200;
      settle();
      check("t3_pf_pmu",       bus.fill_wait_pmu_o, 1'b0);
      check("t3_other_line",   bus.dmd_req_ready_o, 1'b0);
      bus.dmd_req_paddr_i = 40'h11C;
      settle();
      check("t3_promote_ready", bus.dmd_req_ready_o, 1'b1);
      cyc();
      bus.dmd_req_valid_i = 1'b0;
      settle();
      check("t3_promoted_pmu", bus.fill_wait_pmu_o,   1'b1);
      check("t3_no_second_req",bus.ifill_req_valid_o, 1'b0);
      bus.ifill_resp_valid_i = 1'b1;
      bus.ifill_resp_data_i  = d3;
      cyc();
      bus.ifill_resp_valid_i = 1'b0;
      settle();
      check("t3_resp_valid", bus.resp_valid_o, 1'b1);
      check("t3_resp_src",   bus.resp_src_o,   1'b0);
      check("t3_resp_paddr", bus.resp_paddr_o, 40'h100);
      check("t3_resp_data",  bus.resp_data_o,  d3);
      cyc();

      // 4a: flush before ack drops the request
      bus.dmd_req_valid_i = 1'b1;
      bus.dmd_req_paddr_i = 40'h2000;
      cyc();
      bus.dmd_req_valid_i = 1'b0;
      bus.flush_i         = 1'b1;
      settle();
      check("t4_req_before_flush", bus.ifill_req_valid_o, 1'b1);
      cyc();
      bus.flush_i = 1'b0;
      settle();
      check("t4_req_dropped", bus.ifill_req_valid_o, 1'b0);
      check("t4_idle",        bus.busy_o,            1'b0);

      // 4b: flush in WAIT drains and discards the response
      bus.dmd_req_valid_i = 1'b1;
      bus.dmd_req_paddr_i = 40'h3000;
      cyc();
      bus.dmd_req_valid_i  = 1'b0;
      bus.ifill_resp_ack_i = 1'b1;
      cyc();
      bus.ifill_resp_ack_i = 1'b0;
      bus.flush_i          = 1'b1;
      cyc();
      bus.flush_i = 1'b0;
      settle();
      check("t4_drain_busy",  bus.busy_o,            1'b1);
      check("t4_drain_req",   bus.ifill_req_valid_o, 1'b0);
      check("t4_drain_pmu",   bus.fill_wait_pmu_o,   1'b0);
      bus.ifill_resp_valid_i = 1'b1;
      bus.ifill_resp_data_i  = d1;
      cyc();
      bus.ifill_resp_valid_i = 1'b0;
      settle();
      check("t4_discarded", bus.resp_valid_o, 1'b0);
      check("t4_drain_done",bus.busy_o,       1'b0);
      cyc();

      // 5b: dmd_kill_i does not touch a prefetch fill
      bus.pf_req_valid_i = 1'b1;
      bus.pf_req_paddr_i = 40'h4010;
      cyc();
      bus.pf_req_valid_i   = 1'b0;
      bus.dmd_kill_i       = 1'b1;
      bus.ifill_resp_ack_i = 1'b1;
      cyc();
      bus.ifill_resp_ack_i = 1'b0;
      settle();
      check("t5_pf_survives", bus.busy_o, 1'b1);
      bus.ifill_resp_valid_i = 1'b1;
      bus.ifill_resp_data_i  = d2;
      cyc();
      bus.ifill_resp_valid_i = 1'b0;
      bus.dmd_kill_i         = 1'b0;
      settle();
      check("t5_pf_resp_valid", bus.resp_valid_o, 1'b1);
      check("t5_pf_resp_src",   bus.resp_src_o,   1'b1);
      check("t5_pf_resp_paddr", bus.resp_paddr_o, 40'h4000);
      cyc();

      // 6: reset in WAIT, then a stale response beat
      bus.dmd_req_valid_i = 1'b1;
      bus.dmd_req_paddr_i = 40'h5000;
      cyc();
      bus.dmd_req_valid_i  = 1'b0;
      bus.ifill_resp_ack_i = 1'b1;
      cyc();
      bus.ifill_resp_ack_i = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      settle();
      check_quiet("t6_after_rst");
      check("t6_req_paddr", bus.ifill_req_paddr_o, 40'h0);
      bus.ifill_resp_valid_i = 1'b1;
      bus.ifill_resp_data_i  = d3;
      cyc();
      bus.ifill_resp_valid_i = 1'b0;
      settle();
      check_quiet("t6_late_resp");
      check("t6_resp_data",  bus.resp_data_o,  256'h0);
      check("t6_resp_paddr", bus.resp_paddr_o, 40'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
